// File: rtl/rpc_display_pkg.sv
// Shared types, constants and glyph decoding for the RPN calculator display driver.
package rpc_display_pkg;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  // Active-low segments {g,f,e,d,c,b,a}; all ones turns every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble: 16-bit binary to 5-digit BCD, one iteration per clock.
module bcd_seq_converter
  import rpc_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        busy,
  output logic        done
);

  conv_state_t state_q, state_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic [19:0] adj;
  logic [3:0]  nib;

  // State and shift registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
    end
  end

  // Next state: add-3 correction, shift, and restart on start (which may abort a conversion).
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    adj     = bcd_q;
    nib     = '0;
    for (int i = 0; i < 5; i++) begin
      nib = bcd_q[4*i +: 4];
      adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    unique case (state_q)
      CONV_SHIFT: begin
        bcd_d  = {adj[18:0], bin_q[15]};
        bin_d  = {bin_q[14:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = CONV_DONE;
      end
      CONV_DONE: state_d = CONV_IDLE;
      default:   state_d = CONV_IDLE;
    endcase
    if (start) begin
      state_d = CONV_SHIFT;
      bin_d   = bin;
      bcd_d   = '0;
      iter_d  = '0;
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state_q != CONV_IDLE);
  assign done = (state_q == CONV_DONE);

endmodule

// File: rtl/rpc_display_driver.sv
// 8-digit multiplexed 7-segment driver: value (decimal/hex), flags on dps, state on digits 7..6.
module rpc_display_driver
  import rpc_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  flags,
  input  logic [4:0]  state,
  input  logic        hex_mode,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [7:0]  anodes,
  output logic        busy
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [15:0]     cap_val_q;
  logic            cap_hex_q;
  logic [19:0]     dig_q;
  logic            disp_hex_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [7:0]      an_q, an_d;
  logic [4:0]      blank;
  logic            lz;
  logic            change, start, conv_done;
  logic [19:0]     bcd;

  // A new value or mode restarts conversion; a change seen in DONE waits one edge.
  assign change = ({value, hex_mode} != {cap_val_q, cap_hex_q});
  assign start  = change && !conv_done;

  bcd_seq_converter u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (value),
    .bcd   (bcd),
    .busy  (busy),
    .done  (conv_done)
  );

  // Capture the input being converted; commit digits atomically when conversion completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_val_q  <= '0;
      cap_hex_q  <= 1'b0;
      dig_q      <= '0;
      disp_hex_q <= 1'b0;
    end else begin
      if (start) begin
        cap_val_q <= value;
        cap_hex_q <= hex_mode;
      end
      if (conv_done) begin
        dig_q      <= cap_hex_q ? {4'h0, cap_val_q} : bcd;
        disp_hex_q <= cap_hex_q;
      end
    end
  end

  // Leading-zero blanking of the value field; digit 0 always shows.
  always_comb begin
    blank = '0;
    lz    = (BLANK_LZ != 0);
    for (int i = 4; i >= 1; i--) begin
      if (disp_hex_q && i == 4) begin
        blank[i] = 1'b1;
      end else begin
        if (dig_q[4*i +: 4] != 4'h0) lz = 1'b0;
        blank[i] = lz;
      end
    end
  end

  // Scan timing: slot counter and digit index.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Output glyph, dp and anode for the current slot; state and flags are taken live.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = ~(8'b1 << idx_q);
    unique case (idx_q)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
        seg_d = blank[idx_q] ? SEG_BLANK : hex_to_seg(dig_q[4*idx_q +: 4]);
      end
      3'd6:    seg_d = hex_to_seg(state[3:0]);
      3'd7:    seg_d = hex_to_seg({3'b000, state[4]});
      default: seg_d = SEG_BLANK;
    endcase
    if (idx_q < 3'd4) dp_d = ~flags[idx_q[1:0]];
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      an_q  <= 8'hFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign segments = seg_q;
  assign dp       = dp_q;
  assign anodes   = an_q;

endmodule
